// File: rtl/ysyx_24090003_wbu_pkg.sv
// Shared types for the write-back unit: load formats, CSR ops, FSM states and
// the one-entry instruction buffer layout.
package ysyx_24090003_wbu_pkg;

  localparam int          WBU_XLEN     = 32;
  localparam logic [31:0] WBU_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    FMT_LB  = 3'd0,
    FMT_LH  = 3'd1,
    FMT_LW  = 3'd2,
    FMT_LBU = 3'd4,
    FMT_LHU = 3'd5
  } load_fmt_e;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } wbu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_wen;
    logic [31:0] rd_wdata;
    load_fmt_e   fmt;
    logic [1:0]  addr_lo;
    logic        csr_we;
    logic [11:0] csr_addr;
    csr_op_e     csr_op;
    logic [31:0] csr_wdata;
    logic [4:0]  rs1;
    logic        ecall;
    logic        mret;
    logic        jump;
    logic [31:0] jtarget;
  } wbu_buf_t;

endpackage

// File: rtl/ysyx_24090003_load_ext.sv
// Combinational load-data extraction: selects the byte/halfword lane from the
// memory word and sign- or zero-extends it to 32 bits.
module ysyx_24090003_load_ext
  import ysyx_24090003_wbu_pkg::*;
(
  input  load_fmt_e   i_fmt,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    byte_sel = i_rdata[7:0];
      2'd1:    byte_sel = i_rdata[15:8];
      2'd2:    byte_sel = i_rdata[23:16];
      default: byte_sel = i_rdata[31:24];
    endcase
    half_sel = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = '0;
    case (i_fmt)
      FMT_LB:  o_data = {{24{byte_sel[7]}}, byte_sel};
      FMT_LBU: o_data = {24'd0, byte_sel};
      FMT_LH:  o_data = {{16{half_sel[15]}}, half_sel};
      FMT_LHU: o_data = {16'd0, half_sel};
      FMT_LW:  o_data = i_rdata;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24090003_wbu.sv
// Write-back unit: buffers one retired instruction, waits for load data when
// needed and emits a single-cycle commit to the register file and IFU.
//
// state      | meaning
// S_IDLE     | buffer empty, ready to accept
// S_WAIT_MEM | load captured, waiting for the memory read response
// S_COMMIT   | strobes active this cycle; may accept the next instruction
module ysyx_24090003_wbu
  import ysyx_24090003_wbu_pkg::*;
#(
  parameter int              XLEN     = WBU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = WBU_RESET_PC
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_exu_valid,
  output logic            o_exu_ready,
  input  logic [XLEN-1:0] i_exu_pc,
  input  logic [4:0]      i_exu_rd_addr,
  input  logic            i_exu_reg_wen,
  input  logic [XLEN-1:0] i_exu_rd_wdata,
  input  logic            i_exu_is_load,
  input  logic [2:0]      i_exu_load_fmt,
  input  logic [1:0]      i_exu_addr_lo,
  input  logic            i_exu_csr_we,
  input  logic [11:0]     i_exu_csr_addr,
  input  logic [1:0]      i_exu_csr_op,
  input  logic [XLEN-1:0] i_exu_csr_wdata,
  input  logic [4:0]      i_exu_rs1_addr,
  input  logic            i_exu_ecall,
  input  logic            i_exu_mret,
  input  logic            i_exu_jump,
  input  logic [XLEN-1:0] i_exu_jtarget,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_reg_wen,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_wdata,
  output logic [4:0]      o_rs1_addr,
  output logic            o_csr_we,
  output logic [11:0]     o_csr_addr,
  output logic [1:0]      o_csr_op,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_ecall,
  output logic            o_mret,
  output logic [XLEN-1:0] o_pc,
  output logic            o_commit,
  output logic [XLEN-1:0] o_next_pc
);

  wbu_state_e      state_q, state_d;
  wbu_buf_t        buf_q, buf_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] redirect;
  logic            capture;

  ysyx_24090003_load_ext u_load_ext (
    .i_fmt     (buf_q.fmt),
    .i_addr_lo (buf_q.addr_lo),
    .i_rdata   (i_mem_rdata),
    .o_data    (load_data)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    o_exu_ready = (state_q != S_WAIT_MEM);
    capture     = i_exu_valid && o_exu_ready;

    case (state_q)
      S_IDLE, S_COMMIT: begin
        if (capture) begin
          buf_d.pc        = i_exu_pc;
          buf_d.rd        = i_exu_rd_addr;
          buf_d.reg_wen   = i_exu_reg_wen;
          buf_d.rd_wdata  = i_exu_rd_wdata;
          buf_d.fmt       = load_fmt_e'(i_exu_load_fmt);
          buf_d.addr_lo   = i_exu_addr_lo;
          buf_d.csr_we    = i_exu_csr_we;
          buf_d.csr_addr  = i_exu_csr_addr;
          buf_d.csr_op    = csr_op_e'(i_exu_csr_op);
          buf_d.csr_wdata = i_exu_csr_wdata;
          buf_d.rs1       = i_exu_rs1_addr;
          buf_d.ecall     = i_exu_ecall;
          buf_d.mret      = i_exu_mret;
          buf_d.jump      = i_exu_jump;
          buf_d.jtarget   = i_exu_jtarget;
          state_d         = i_exu_is_load ? S_WAIT_MEM : S_COMMIT;
        end else if (state_q == S_COMMIT) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_MEM: begin
        if (i_mem_rvalid) begin
          buf_d.rd_wdata = load_data;
          state_d        = S_COMMIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Trap entry wins over return, which wins over a taken jump.
  always_comb begin
    if (buf_q.ecall)      redirect = i_mtvec;
    else if (buf_q.mret)  redirect = i_mepc;
    else if (buf_q.jump)  redirect = buf_q.jtarget;
    else                  redirect = buf_q.pc + 32'd4;

    o_commit    = (state_q == S_COMMIT);
    o_reg_wen   = o_commit && buf_q.reg_wen && (buf_q.rd != 5'd0) && !buf_q.ecall;
    o_csr_we    = o_commit && buf_q.csr_we && !buf_q.ecall;
    o_ecall     = o_commit && buf_q.ecall;
    o_mret      = o_commit && buf_q.mret && !buf_q.ecall;
    o_rd_addr   = buf_q.rd;
    o_rd_wdata  = buf_q.rd_wdata;
    o_rs1_addr  = buf_q.rs1;
    o_csr_addr  = buf_q.csr_addr;
    o_csr_op    = buf_q.csr_op;
    o_csr_wdata = buf_q.csr_wdata;
    o_pc        = buf_q.pc;
    // Outside a commit the IFU keeps seeing the last redirect (RESET_PC after reset).
    next_pc_d   = o_commit ? redirect : next_pc_q;
    o_next_pc   = next_pc_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      next_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      next_pc_q <= next_pc_d;
    end
  end

endmodule
